// File: rtl/gate_bank_bist.sv
// Bank of CHANNELS registered two-input gates (AND/NAND/OR/XOR) with an exhaustive
// truth-table self-test sequencer. Optional stuck-at-0 fault injection: GATE_BANK_FAULT_INJ_EN.
module gate_bank_bist #(
   parameter int CHANNELS  = 4,
   parameter int FAIL_CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [CHANNELS-1:0]   i_a,
   input  logic [CHANNELS-1:0]   i_b,
   input  logic [1:0]            i_mode,
   output logic [CHANNELS-1:0]   o_y,
   input  logic                  i_bist_start,
   output logic                  o_bist_busy,
   output logic                  o_bist_done,
   output logic                  o_bist_pass,
   output logic [FAIL_CH_W-1:0]  o_bist_fail_ch,
   output logic [1:0]            o_bist_fail_vec
`ifdef GATE_BANK_FAULT_INJ_EN
   ,
   input  logic                  i_fault_en,
   input  logic [FAIL_CH_W-1:0]  i_fault_ch
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [FAIL_CH_W-1:0] LAST_CH = FAIL_CH_W'(CHANNELS - 1);

   state_t                r_state, w_state_next;
   logic [1:0]            r_test_mode, w_test_mode_next;
   logic [FAIL_CH_W-1:0]  r_ch, w_ch_next;
   logic [1:0]            r_vec, w_vec_next;
   logic                  r_pass, w_pass_next;
   logic [FAIL_CH_W-1:0]  r_fail_ch, w_fail_ch_next;
   logic [1:0]            r_fail_vec, w_fail_vec_next;
   logic [CHANNELS-1:0]   r_y, w_y_next;

   logic [CHANNELS-1:0]   w_a_sel, w_b_sel, w_gate, w_fault_mask;
   logic [1:0]            w_mode_sel;
   logic                  w_vec_a, w_vec_b;
   logic                  w_expect, w_observed;

   function automatic logic gate_f(input logic [1:0] mode, input logic a, input logic b);
      case (mode)
         2'd0:    return a & b;
         2'd1:    return ~(a & b);
         2'd2:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // Vector order (1,1),(0,1),(1,0),(0,0) is simply the inverted vector index bits.
   assign w_vec_a    = ~r_vec[0];
   assign w_vec_b    = ~r_vec[1];
   assign w_mode_sel = (r_state == ST_IDLE) ? i_mode : r_test_mode;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign w_a_sel[gi] = (r_state == ST_APPLY) ? w_vec_a : i_a[gi];
         assign w_b_sel[gi] = (r_state == ST_APPLY) ? w_vec_b : i_b[gi];
         assign w_gate[gi]  = gate_f(w_mode_sel, w_a_sel[gi], w_b_sel[gi]);
      end
   endgenerate

`ifdef GATE_BANK_FAULT_INJ_EN
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_fault
         assign w_fault_mask[gi] = i_fault_en && (i_fault_ch == FAIL_CH_W'(gi));
      end
   endgenerate
`else
   assign w_fault_mask = '0;
`endif

   assign w_expect   = gate_f(r_test_mode, w_vec_a, w_vec_b);
   assign w_observed = r_y[r_ch];

   always_comb begin
      w_state_next     = r_state;
      w_test_mode_next = r_test_mode;
      w_ch_next        = r_ch;
      w_vec_next       = r_vec;
      w_pass_next      = r_pass;
      w_fail_ch_next   = r_fail_ch;
      w_fail_vec_next  = r_fail_vec;
      w_y_next         = r_y;

      case (r_state)
         ST_IDLE: begin
            w_y_next = w_gate;
            if (i_bist_start) begin
               w_test_mode_next = i_mode;
               w_ch_next        = '0;
               w_vec_next       = 2'd0;
               w_pass_next      = 1'b0;
               w_fail_ch_next   = '0;
               w_fail_vec_next  = 2'd0;
               w_state_next     = ST_APPLY;
            end
         end
         ST_APPLY: begin
            w_y_next     = w_gate;
            w_state_next = ST_CHECK;
         end
         ST_CHECK: begin
            // Y holds the applied vector here; only the selected channel is judged.
            if (w_observed != w_expect) begin
               w_fail_ch_next  = r_ch;
               w_fail_vec_next = r_vec;
               w_pass_next     = 1'b0;
               w_state_next    = ST_DONE;
            end else if (r_vec != 2'd3) begin
               w_vec_next   = r_vec + 2'd1;
               w_state_next = ST_APPLY;
            end else if (r_ch != LAST_CH) begin
               w_ch_next    = r_ch + 1'b1;
               w_vec_next   = 2'd0;
               w_state_next = ST_APPLY;
            end else begin
               w_pass_next  = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_test_mode <= 2'd0;
         r_ch        <= '0;
         r_vec       <= 2'd0;
         r_pass      <= 1'b0;
         r_fail_ch   <= '0;
         r_fail_vec  <= 2'd0;
         r_y         <= '0;
      end else begin
         r_state     <= w_state_next;
         r_test_mode <= w_test_mode_next;
         r_ch        <= w_ch_next;
         r_vec       <= w_vec_next;
         r_pass      <= w_pass_next;
         r_fail_ch   <= w_fail_ch_next;
         r_fail_vec  <= w_fail_vec_next;
         r_y         <= w_y_next & ~w_fault_mask;
      end
   end

   assign o_y             = r_y;
   assign o_bist_busy     = (r_state == ST_APPLY) || (r_state == ST_CHECK);
   assign o_bist_done     = (r_state == ST_DONE);
   assign o_bist_pass     = r_pass;
   assign o_bist_fail_ch  = r_fail_ch;
   assign o_bist_fail_vec = r_fail_vec;

endmodule

// File: doc/gate_bank_bist.md
# gate_bank_bist

Parametrised bank of CHANNELS two-input logic gates with registered outputs, a runtime function select (AND/NAND/OR/XOR), and a built-in self-test sequencer. It is the next generation of the quad 2-input AND part in the 74xx library. It generalises channel count and gate function. It adds an on-chip exhaustive truth-table sweep that reports pass/fail and the first failing channel and vector, so board-level models can self-check without a bench.

## Interface
Parameters:
- CHANNELS, 4, number of gate channels (1..32)
- FAIL_CH_W, $clog2(CHANNELS) (min 1), width of BIST_FAIL_CH

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- A  in  CHANNELS  gate input A per channel
- B  in  CHANNELS  gate input B per channel
- MODE  in  2  function: 0 AND, 1 NAND, 2 OR, 3 XOR
- Y  out  CHANNELS  registered gate outputs
- BIST_START  in  1  request self-test (level, sampled in IDLE)
- BIST_BUSY  out  1  self-test in progress
- BIST_DONE  out  1  one-cycle pulse at test end
- BIST_PASS  out  1  result of last completed test
- BIST_FAIL_CH  out  FAIL_CH_W  first failing channel
- BIST_FAIL_VEC  out  2  first failing vector index

## Operation
- Reset: Y=0, BIST_BUSY=0, BIST_DONE=0, BIST_PASS=0, BIST_FAIL_CH=0, BIST_FAIL_VEC=0, FSM=IDLE.
- Functional mode (IDLE): every edge, Y[i] <= f(MODE, A[i], B[i]) for all i.
- Test vectors in fixed order: index 0 = (A=1,B=1), 1 = (0,1), 2 = (1,0), 3 = (0,0).
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE: on BIST_START=1, latch MODE into test_mode, ch=0, vec=0, clear PASS/FAIL_CH/FAIL_VEC, go APPLY.
  - APPLY: gate inputs of all channels are muxed to vector[vec]; Y captures f(test_mode, vector) at this edge; go CHECK.
  - CHECK: compare Y[ch] with expected f(test_mode, vector[vec]).
    - On mismatch: FAIL_CH=ch, FAIL_VEC=vec, PASS=0, go DONE.
    - On match with vec<3: vec++, go APPLY.
    - On match with vec==3 and ch<CHANNELS-1: ch++, vec=0, go APPLY.
    - On match with vec==3 and ch==CHANNELS-1: PASS=1, go DONE.
  - DONE: BIST_DONE=1 for this single cycle, BUSY=0; next edge go IDLE. Functional Y update resumes from IDLE.
- Behaviour while BUSY:
  - A, B, MODE and BIST_START are ignored.
  - Y shows BIST-driven values.
  - Checking is one channel at a time, first failure aborts.
- Results (PASS, FAIL_CH, FAIL_VEC) hold until the next accepted BIST_START.
- BIST_START held high: a new test starts on the first IDLE cycle after DONE.
- RST at any time, including mid-test, forces the reset state immediately; no DONE pulse is issued.

## Timing
- Functional latency: 1 cycle, A/B/MODE to Y.
- Let edge k be the edge at which BIST_START is sampled in IDLE. BUSY=1 from after edge k.
- Each vector costs 2 edges (APPLY, CHECK).
- All pass: final CHECK at edge k+8·CHANNELS. DONE=1 and BUSY=0 in the cycle after that edge. PASS=1 is visible in the same cycle.
- Failure at channel c, vector v: DONE is high in the cycle after edge k+8c+2v+2.
- Idle-to-idle for a passing run: 8·CHANNELS+2 edges.

## Configuration
- GATE_BANK_FAULT_INJ_EN defined:
  - Adds ports FAULT_EN (in, 1) and FAULT_CH (in, FAIL_CH_W).
  - While FAULT_EN=1, register Y[FAULT_CH] is forced stuck-at-0 in both functional and BIST operation.
  - An out-of-range FAULT_CH has no effect.
- Not defined: neither port exists and no fault logic is present.

## Test plan
- Functional: CHANNELS=4, MODE=0, A=4'b1011, B=4'b1110 -> Y=4'b1010 one edge later. MODE=3, same A/B -> Y=4'b0101.
- Passing BIST: MODE=2, pulse BIST_START at edge k -> BUSY high for 32 cycles, DONE pulse after edge k+32, PASS=1, FAIL_CH=0, FAIL_VEC=0.
- Fault, AND mode (macro on): FAULT_EN=1, FAULT_CH=2, MODE=0 -> DONE after edge k+18, PASS=0, FAIL_CH=2, FAIL_VEC=0.
- Fault, XOR mode: same fault, MODE=3 -> vector 0 passes (expected 0). DONE after edge k+20, FAIL_CH=2, FAIL_VEC=1.
- Abort and ignore: assert RST at edge k+10 of a run -> all outputs 0, no DONE, Y=0. Toggling MODE, A and BIST_START mid-run (no reset) -> result unchanged vs. an undisturbed run.
- Re-run: hold BIST_START high -> second run begins one cycle after DONE, and PASS is cleared at its start.
